// File: rtl/i2s_transmitter.sv
// i2s_transmitter: Philips-format I2S serialiser for stereo PCM pairs.
// Derives SCLK/LRCLK from MCLK and shifts each word out MSB first, starting one
// SCLK after the LRCLK edge. A one-entry holding register in front of the frame
// register gives a full frame of slack on the input side.
// Ports:
//   mclk       in   master clock, the only clock of the block
//   rst        in   synchronous active-high reset
//   din_left   in   left sample (two's complement)
//   din_right  in   right sample (two's complement)
//   din_valid  in   sample pair valid
//   din_ready  out  hold register empty; transfer on din_valid & din_ready
//   sdout      out  I2S serial data, changes on falling SCLK
//   mclk_out   out  mclk pass-through (combinational)
//   sclk_out   out  bit clock, mclk/MCLK_DIV, 50% duty
//   lrclk_out  out  word select, 0 = left slot, 1 = right slot
//   underrun   out  one-cycle pulse when a frame loads with no pending pair
module i2s_transmitter #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned MCLK_DIV = 8
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din_left,
  input  logic [DATA_W-1:0] din_right,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sdout,
  output logic              mclk_out,
  output logic              sclk_out,
  output logic              lrclk_out,
  output logic              underrun
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_W;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
  localparam int unsigned DIV_W      = $clog2(MCLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCLK_DIV / 2);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_C   = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] DATA_C   = CNT_W'(DATA_W);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              hold_empty_q, hold_empty_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_W-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
  logic              sclk_q, sclk_d;
  logic              lrclk_q, lrclk_d;
  logic              sdout_q, sdout_d;
  logic              underrun_q, underrun_d;

  logic              div_wrap;
  logic              frame_load;
  logic              accept;
  logic [CNT_W-1:0]  pos;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] word_sh;

  // Next-state logic; outputs are derived from next-state counters so they
  // settle in the same cycle the counters do.
  always_comb begin
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    hold_empty_d = hold_empty_q;
    hold_l_d     = hold_l_q;
    hold_r_d     = hold_r_q;
    tx_l_d       = tx_l_q;
    tx_r_d       = tx_r_q;
    underrun_d   = 1'b0;
    sdout_d      = 1'b0;
    word_sh      = '0;

    div_wrap   = (div_cnt_q == DIV_LAST);
    frame_load = div_wrap && (bit_cnt_q == BIT_LAST);
    accept     = din_valid && hold_empty_q;

    div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    if (div_wrap) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
    end

    // Frame boundary: move the held pair in, or send silence and flag it.
    if (frame_load) begin
      if (!hold_empty_q) begin
        tx_l_d       = hold_l_q;
        tx_r_d       = hold_r_q;
        hold_empty_d = 1'b1;
      end else begin
        tx_l_d     = '0;
        tx_r_d     = '0;
        underrun_d = 1'b1;
      end
    end

    // Accept only while empty, so this never collides with a successful load.
    if (accept) begin
      hold_l_d     = din_left;
      hold_r_d     = din_right;
      hold_empty_d = 1'b0;
    end

    sclk_d  = (div_cnt_d >= DIV_HALF);
    lrclk_d = (bit_cnt_d >= SLOT_C);
    pos     = lrclk_d ? bit_cnt_d - SLOT_C : bit_cnt_d;
    word    = lrclk_d ? tx_r_d : tx_l_d;

    // Slot position 0 is the Philips one-bit delay; positions past the word pad with 0.
    if ((pos != '0) && (pos <= DATA_C)) begin
      word_sh = word >> (DATA_C - pos);
      sdout_d = word_sh[0];
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      hold_empty_q <= 1'b1;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
      tx_l_q       <= '0;
      tx_r_q       <= '0;
      sclk_q       <= 1'b0;
      lrclk_q      <= 1'b0;
      sdout_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      hold_empty_q <= hold_empty_d;
      hold_l_q     <= hold_l_d;
      hold_r_q     <= hold_r_d;
      tx_l_q       <= tx_l_d;
      tx_r_q       <= tx_r_d;
      sclk_q       <= sclk_d;
      lrclk_q      <= lrclk_d;
      sdout_q      <= sdout_d;
      underrun_q   <= underrun_d;
    end
  end

  assign din_ready = hold_empty_q;
  assign sdout     = sdout_q;
  assign mclk_out  = mclk;
  assign sclk_out  = sclk_q;
  assign lrclk_out = lrclk_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: drives i2s_transmitter with directed and random pairs,
// compares every mclk cycle against a frame-level reference model and decodes
// sdout at rising SCLK edges to check the transmitted words.
module tb_i2s_transmitter;

  localparam int unsigned DW    = 24;
  localparam int unsigned SW    = 32;
  localparam int unsigned DIV   = 8;
  localparam int unsigned FRAME = 2 * SW * DIV;

  logic          mclk = 1'b0;
  logic          rst  = 1'b1;
  logic [DW-1:0] din_left  = '0;
  logic [DW-1:0] din_right = '0;
  logic          din_valid = 1'b0;
  logic          din_ready, sdout, mclk_out, sclk_out, lrclk_out, underrun;

  i2s_transmitter #(.DATA_W(DW), .SLOT_W(SW), .MCLK_DIV(DIV)) dut (
    .mclk      (mclk),
    .rst       (rst),
    .din_left  (din_left),
    .din_right (din_right),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sdout     (sdout),
    .mclk_out  (mclk_out),
    .sclk_out  (sclk_out),
    .lrclk_out (lrclk_out),
    .underrun  (underrun)
  );

  always #5 mclk = ~mclk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: cycle index since reset plus hold/frame words.
  int            c = 0;
  bit            m_full = 1'b0;
  bit            m_under = 1'b0;
  bit            m_acc = 1'b0;
  logic [DW-1:0] m_hl = '0, m_hr = '0, m_tl = '0, m_tr = '0;

  // sdout decoder state
  int            rx_pos = 0;
  bit            prev_sclk = 1'b0, prev_lr = 1'b0, rx_pad_bad = 1'b0;
  logic [DW-1:0] rx_l = '0, rx_r = '0;
  logic [DW-1:0] dec_l[$], dec_r[$];
  bit            dec_pad[$];

  task automatic model_edge();
    bit was_full;
    bit load;
    m_acc = 1'b0;
    if (rst) begin
      c = 0; m_full = 1'b0; m_under = 1'b0; m_tl = '0; m_tr = '0;
      rx_pos = 0; prev_sclk = 1'b0; prev_lr = 1'b0; rx_pad_bad = 1'b0;
      rx_l = '0; rx_r = '0;
      dec_l.delete(); dec_r.delete(); dec_pad.delete();
    end else begin
      was_full = m_full;
      load     = (c % FRAME) == FRAME - 1;
      m_under  = load && !was_full;
      if (load) begin
        if (was_full) begin m_tl = m_hl; m_tr = m_hr; m_full = 1'b0; end
        else begin m_tl = '0; m_tr = '0; end
      end
      if (din_valid && !was_full) begin
        m_hl = din_left; m_hr = din_right; m_full = 1'b1; m_acc = 1'b1;
      end
      c++;
    end
  endtask

  task automatic check_cycle();
    int            div, bc, b;
    bit            lr, sd;
    logic [DW-1:0] word, sh;
    logic [5:0]    e, o;
    div  = c % DIV;
    bc   = (c / DIV) % (2 * SW);
    b    = bc % SW;
    lr   = bc >= SW;
    word = lr ? m_tr : m_tl;
    sd   = 1'b0;
    if (b >= 1 && b <= DW) begin
      sh = word >> (DW - b);
      sd = sh[0];
    end
    e = {1'b0, !m_full, m_under, sd, div >= DIV / 2, lr};
    o = {mclk_out, din_ready, underrun, sdout, sclk_out, lrclk_out};
    chk("outs{mclk,rdy,unr,sd,sclk,lr}", 32'(o), 32'(e));
  endtask

  task automatic decode();
    if (!lrclk_out && prev_lr) begin
      dec_l.push_back(rx_l); dec_r.push_back(rx_r); dec_pad.push_back(rx_pad_bad);
      rx_l = '0; rx_r = '0; rx_pad_bad = 1'b0; rx_pos = 0;
    end
    if (sclk_out && !prev_sclk && rx_pos < 2 * SW) begin
      if ((rx_pos % SW) >= 1 && (rx_pos % SW) <= DW) begin
        if (sdout) begin
          if (rx_pos >= SW) rx_r = rx_r | (DW'(1) << (DW - (rx_pos % SW)));
          else              rx_l = rx_l | (DW'(1) << (DW - (rx_pos % SW)));
        end
      end else if (sdout) begin
        rx_pad_bad = 1'b1;
      end
      rx_pos++;
    end
    prev_sclk = sclk_out;
    prev_lr   = lrclk_out;
  endtask

  task automatic tick();
    @(posedge mclk);
    model_edge();
    @(negedge mclk);
    #1;
    check_cycle();
    if (!rst) decode();
  endtask

  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // Offer a pair until the model accepts it; din_valid stays high afterwards.
  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int guard = 0;
    din_left = l; din_right = r; din_valid = 1'b1;
    do begin tick(); guard++; end while (!m_acc && guard < 2 * FRAME);
    if (!m_acc) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_frames(input int n);
    int guard = 0;
    while (dec_l.size() < n && guard < (n + 2) * FRAME) begin tick(); guard++; end
    if (dec_l.size() < n) chk("frame_timeout", 32'(dec_l.size()), 32'(n));
  endtask

  task automatic run_to_cycle(input int target);
    while (c < target) tick();
  endtask

  task automatic chk_frame(input string tag, input int k, input logic [DW-1:0] l,
                           input logic [DW-1:0] r);
    chk({tag, "_left"},  32'(dec_l[k]), 32'(l));
    chk({tag, "_right"}, 32'(dec_r[k]), 32'(r));
    chk({tag, "_pad"},   32'(dec_pad[k]), 32'(0));
  endtask

  logic [DW-1:0] pl[3] = '{24'h123456, 24'hABCDEF, 24'h7FFFFF};
  logic [DW-1:0] pr[3] = '{24'h654321, 24'h000001, 24'h800001};
  int            unr_cnt;

  initial begin
    // Reset, single pair, then starvation
    do_reset();
    chk("reset_ready", 32'(din_ready), 32'(1));
    push(24'hC3A5F0, 24'h0F0F0F);
    din_valid = 1'b0;
    wait_frames(4);
    chk_frame("t1_f0", 0, '0, '0);
    chk_frame("t1_f1", 1, 24'hC3A5F0, 24'h0F0F0F);
    chk_frame("t4_f2", 2, '0, '0);
    chk_frame("t4_f3", 3, '0, '0);

    // Three pairs back to back with din_valid held high
    do_reset();
    for (int k = 0; k < 3; k++) push(pl[k], pr[k]);
    din_valid = 1'b0;
    wait_frames(5);
    for (int k = 0; k < 3; k++) chk_frame($sformatf("t3_pair%0d", k), k + 1, pl[k], pr[k]);
    chk_frame("t3_after", 4, '0, '0);

    // Full-scale extremes
    do_reset();
    push(24'hFFFFFF, 24'h800000);
    din_valid = 1'b0;
    wait_frames(2);
    chk_frame("t5", 1, 24'hFFFFFF, 24'h800000);

    // Reset mid right slot with a pair waiting in hold
    do_reset();
    push(24'h111111, 24'h222222);
    din_valid = 1'b0;
    run_to_cycle(FRAME + 10);
    push(24'hDEAD01, 24'hBEEF02);
    din_valid = 1'b0;
    run_to_cycle(FRAME + SW * DIV + 100);
    do_reset();
    chk("t6_ready", 32'(din_ready), 32'(1));
    chk("t6_outs", 32'({sdout, sclk_out, lrclk_out, underrun}), 32'(0));
    unr_cnt = 0;
    for (int i = 0; i < FRAME - 2; i++) begin tick(); unr_cnt += int'(underrun); end
    chk("t6_no_underrun_f0", 32'(unr_cnt), 32'(0));
    wait_frames(3);
    for (int k = 0; k < 3; k++) chk_frame($sformatf("t6_f%0d", k), k, '0, '0);

    // Random traffic with sparse valids and occasional resets
    do_reset();
    for (int i = 0; i < 16000; i++) begin
      din_valid = ($urandom_range(0, 999) < 4);
      din_left  = DW'($urandom);
      din_right = DW'($urandom);
      rst       = ($urandom_range(0, 7999) == 0);
      tick();
    end
    rst = 1'b0; din_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
